seq_divider: RTL and testbench



---
 rtl/seq_divider.sv | 127 ++++++++++++
 tb/tb_seq_divider.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per clock, WIDTH iterations,
// one-cycle done pulse with registered quotient/remainder/div_by_zero.
module seq_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_ZERO
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic             take;

  // Trial subtraction: add one's complement of {0,divisor} with carry-in 1;
  // a clear MSB means the shifted partial remainder was >= divisor.
  always_comb begin
    r_sh  = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial = r_sh + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
    take  = ~trial[WIDTH];
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // In ZERO the Q register simply carries the sampled dividend to the remainder.
          dvs_d   = divisor;
          q_d     = dividend;
          r_d     = '0;
          cnt_d   = '0;
          state_d = (divisor == '0) ? S_ZERO : S_CALC;
        end
      end
      S_CALC: begin
        r_d   = take ? trial : r_sh;
        q_d   = {q_q[WIDTH-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      S_ZERO: begin
        quot_d  = '1;
        rem_d   = q_q;
        dbz_d   = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: cycle-level behavioural model using plain
// division, per-cycle output compare, directed literal cases and random operands.
module tb_seq_divider;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles remaining until done, and the pending result.
  logic [5:0]   m_cnt = '0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_q = '0, m_r = '0;
  logic         m_z = 1'b0;
  logic [W-1:0] e_q = '0, e_r = '0;
  logic         e_z = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= '0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_z    <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_done <= 1'b1;
          m_q    <= e_q;
          m_r    <= e_r;
          m_z    <= e_z;
        end
      end else if (start) begin
        if (divisor == 0) begin
          m_cnt <= 6'd1;
          e_q   <= '1;
          e_r   <= dividend;
          e_z   <= 1'b1;
        end else begin
          m_cnt <= 6'(W);
          e_q   <= dividend / divisor;
          e_r   <= dividend % divisor;
          e_z   <= 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", busy, m_cnt != 0);
    chk("done", done, m_done);
    chk("quotient_hold", quotient, m_q);
    chk("remainder_hold", remainder, m_r);
    chk("dbz_hold", div_by_zero, m_z);
  end

  task automatic launch_now(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    launch_now(a, b);
  endtask

  task automatic wait_done(input bit noise, input int exp_lat,
                           input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez);
    int lat;
    bit got;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) got = 1'b1;
      else if (noise) begin
        start    = 1'($urandom_range(0, 1));
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
    end
    start = 1'b0;
    chk("done_seen", got, 1);
    chk("latency", lat, exp_lat);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] a, b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;

    launch(16'd100, 16'd7);
    wait_done(1'b0, 16, 16'd14, 16'd2, 1'b0);

    launch(16'hFFFF, 16'd1);
    wait_done(1'b0, 16, 16'hFFFF, 16'd0, 1'b0);
    launch(16'hFFFF, 16'hFFFF);
    wait_done(1'b0, 16, 16'd1, 16'd0, 1'b0);
    launch(16'd5, 16'd9);
    wait_done(1'b0, 16, 16'd0, 16'd5, 1'b0);

    launch(16'd1234, 16'd0);
    wait_done(1'b0, 1, 16'hFFFF, 16'd1234, 1'b1);
    launch(16'd10, 16'd3);
    wait_done(1'b0, 16, 16'd3, 16'd1, 1'b0);

    // start pulsed at cycle 4 of a busy operation must be ignored
    launch(16'd1000, 16'd3);
    repeat (3) @(posedge clk);
    #1;
    launch_now(16'd50, 16'd5);
    wait_done(1'b0, 12, 16'd333, 16'd1, 1'b0);
    launch_now(16'd50, 16'd5);
    wait_done(1'b0, 16, 16'd10, 16'd0, 1'b0);

    // asynchronous reset mid-division
    launch(16'd500, 16'd7);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_quotient", quotient, 0);
    chk("arst_remainder", remainder, 0);
    chk("arst_dbz", div_by_zero, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("no_done_after_reset", quotient, 0);
    launch(16'd81, 16'd9);
    wait_done(1'b0, 16, 16'd9, 16'd0, 1'b0);

    for (int n = 0; n < 2000; n++) begin
      a = W'($urandom);
      if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 15));
      else b = W'($urandom_range(1, 65535));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
      launch(a, b);
      wait_done(1'b1, 16, a / b, a % b, 1'b0);
    end

    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
